// File: rtl/mandel_pixel_scheduler.sv
// rtl/mandel_pixel_scheduler.sv - raster-order job dispatcher and result re-serialiser for parallel iteration engines
module mandel_pixel_scheduler #(
    parameter int NUM_ENG = 2,
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480,
    parameter int ITER_W  = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      frame_start,
    input  logic                      continuous,
    output logic                      busy,
    output logic                      frame_done,
    output logic [NUM_ENG-1:0]        eng_start_valid,
    input  logic [NUM_ENG-1:0]        eng_start_ready,
    output logic [9:0]                eng_x,
    output logic [8:0]                eng_y,
    input  logic [NUM_ENG-1:0]        eng_res_valid,
    input  logic [NUM_ENG*ITER_W-1:0] eng_res_iter,
    output logic [NUM_ENG-1:0]        eng_res_ready,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [ITER_W-1:0]         pix_iter,
    output logic                      pix_sof,
    output logic                      pix_eol
);

    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_next;
    logic [9:0]         ix, rx;
    logic [8:0]         iy, ry;
    logic [PTR_W-1:0]   iss_ptr, ret_ptr;
    logic [NUM_ENG-1:0] outstanding;
    logic               out_last;

    logic               iss_busy, ret_busy;
    logic [ITER_W-1:0]  ret_iter;
    logic               iss_hs, res_hs, pix_hs, last_pix_hs, frame_clear;
    logic               iss_last, ret_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_ENG - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign eng_x = ix;
    assign eng_y = iy;
    assign busy  = (state != IDLE);

    always_comb begin
        iss_busy = 1'b0;
        ret_busy = 1'b0;
        ret_iter = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (iss_ptr == PTR_W'(k)) iss_busy = outstanding[k];
            if (ret_ptr == PTR_W'(k)) begin
                ret_busy = outstanding[k];
                ret_iter = eng_res_iter[k*ITER_W +: ITER_W];
            end
        end
    end

    always_comb begin
        eng_start_valid = '0;
        eng_res_ready   = '0;
        if (state == RUN && !iss_busy)
            eng_start_valid = NUM_ENG'(1) << iss_ptr;
        if (state != IDLE && ret_busy && (!pix_valid || pix_ready))
            eng_res_ready = NUM_ENG'(1) << ret_ptr;
        iss_hs      = |(eng_start_valid & eng_start_ready);
        res_hs      = |(eng_res_ready & eng_res_valid);
        pix_hs      = pix_valid && pix_ready;
        last_pix_hs = (state == DRAIN) && pix_hs && out_last;
        frame_done  = last_pix_hs;
        iss_last    = (ix == 10'(X_SIZE - 1)) && (iy == 9'(Y_SIZE - 1));
        ret_last    = (rx == 10'(X_SIZE - 1)) && (ry == 9'(Y_SIZE - 1));
    end

    always_comb begin
        state_next  = state;
        frame_clear = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next  = RUN;
                    frame_clear = 1'b1;
                end
            end
            RUN: begin
                if (iss_hs && iss_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (last_pix_hs) begin
                    state_next  = continuous ? RUN : IDLE;
                    frame_clear = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            ix          <= '0;
            iy          <= '0;
            rx          <= '0;
            ry          <= '0;
            iss_ptr     <= '0;
            ret_ptr     <= '0;
            outstanding <= '0;
            pix_valid   <= 1'b0;
            pix_iter    <= '0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            state <= state_next;
            // Issue sees the pre-clear outstanding bit, so an engine retiring this cycle is re-issued next cycle.
            outstanding <= (outstanding | (eng_start_valid & eng_start_ready))
                         & ~(eng_res_ready & eng_res_valid);
            if (frame_clear) begin
                ix      <= '0;
                iy      <= '0;
                rx      <= '0;
                ry      <= '0;
                iss_ptr <= '0;
                ret_ptr <= '0;
            end else begin
                if (iss_hs) begin
                    iss_ptr <= ptr_inc(iss_ptr);
                    if (ix == 10'(X_SIZE - 1)) begin
                        ix <= '0;
                        iy <= (iy == 9'(Y_SIZE - 1)) ? 9'd0 : iy + 9'd1;
                    end else begin
                        ix <= ix + 10'd1;
                    end
                end
                if (res_hs) begin
                    ret_ptr <= ptr_inc(ret_ptr);
                    if (rx == 10'(X_SIZE - 1)) begin
                        rx <= '0;
                        ry <= (ry == 9'(Y_SIZE - 1)) ? 9'd0 : ry + 9'd1;
                    end else begin
                        rx <= rx + 10'd1;
                    end
                end
            end
            if (res_hs) begin
                pix_valid <= 1'b1;
                pix_iter  <= ret_iter;
                pix_sof   <= (rx == 10'd0) && (ry == 9'd0);
                pix_eol   <= (rx == 10'(X_SIZE - 1));
                out_last  <= ret_last;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// tb/tb_mandel_pixel_scheduler.sv - randomized self-checking bench for mandel_pixel_scheduler
module tb_mandel_pixel_scheduler;
    localparam int NE = 2, XS = 4, YS = 2, IW = 8, FP = XS * YS;

    logic              aclk = 1'b0;
    logic              areset, frame_start, continuous, busy, frame_done;
    logic [NE-1:0]     eng_start_valid, eng_start_ready, eng_res_valid, eng_res_ready;
    logic [9:0]        eng_x;
    logic [8:0]        eng_y;
    logic [NE*IW-1:0]  eng_res_iter;
    logic              pix_valid, pix_ready, pix_sof, pix_eol;
    logic [IW-1:0]     pix_iter;

    always #5 aclk = ~aclk;

    mandel_pixel_scheduler #(.NUM_ENG(NE), .X_SIZE(XS), .Y_SIZE(YS), .ITER_W(IW)) dut (
        .aclk(aclk), .areset(areset), .frame_start(frame_start), .continuous(continuous),
        .busy(busy), .frame_done(frame_done),
        .eng_start_valid(eng_start_valid), .eng_start_ready(eng_start_ready),
        .eng_x(eng_x), .eng_y(eng_y),
        .eng_res_valid(eng_res_valid), .eng_res_iter(eng_res_iter), .eng_res_ready(eng_res_ready),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_iter(pix_iter),
        .pix_sof(pix_sof), .pix_eol(pix_eol)
    );

    int checks = 0, errors = 0;

    // Model: pixel i of the run is issued to engine i%NE and must leave as the i-th output.
    bit busy_m, out_full;
    int iss_n, ret_n, out_idx, in_frame, pix_cnt, frames, sofs, cyc;
    bit has_job [NE];
    int job_iter[NE], dly[NE], fix_dly[NE];
    int mult, salt, hold_cnt, cap_n;
    int cap[8];
    bit rnd_dly, rnd_pix, rnd_srdy, rnd_fs, fs_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pix_val(input int i);
        return (i * mult + salt) & 255;
    endfunction

    task automatic drive();
        for (int k = 0; k < NE; k++) begin
            eng_res_valid[k]           = has_job[k] && dly[k] == 0;
            eng_res_iter[k*IW +: IW]   = IW'(job_iter[k]);
            eng_start_ready[k]         = rnd_srdy ? 1'($urandom % 2) : 1'b1;
        end
        pix_ready   = rnd_pix ? 1'($urandom % 2) : 1'b1;
        frame_start = fs_req || (rnd_fs && ($urandom % 3 == 0));
        fs_req      = 1'b0;
    endtask

    task automatic model_reset();
        busy_m = 0; out_full = 0;
        iss_n = 0; ret_n = 0; out_idx = 0; in_frame = 0;
        for (int k = 0; k < NE; k++) begin
            has_job[k] = 0; job_iter[k] = 0; dly[k] = 0;
        end
        fs_req = 0; rnd_fs = 0;
        drive();
    endtask

    task automatic step();
        logic [NE-1:0] exp_sv, exp_rr;
        bit iss_hs, res_hs, pix_hs, fd;
        int ik, rk;
        @(negedge aclk);
        ik = iss_n % NE;
        rk = ret_n % NE;
        exp_sv = '0;
        exp_rr = '0;
        if (busy_m && in_frame < FP && !has_job[ik]) exp_sv[ik] = 1'b1;
        if (has_job[rk] && (!out_full || pix_ready)) exp_rr[rk] = 1'b1;
        fd = out_full && pix_ready && (out_idx % FP == FP - 1);
        check("busy", busy, busy_m);
        check("pix_valid", pix_valid, out_full);
        check("eng_start_valid", eng_start_valid, exp_sv);
        check("eng_res_ready", eng_res_ready, exp_rr);
        check("frame_done", frame_done, fd);
        if (exp_sv != 0) begin
            check("eng_x", eng_x, (iss_n % FP) % XS);
            check("eng_y", eng_y, (iss_n % FP) / XS);
        end
        if (out_full) begin
            check("pix_iter", pix_iter, pix_val(out_idx));
            check("pix_sof", pix_sof, out_idx % FP == 0);
            check("pix_eol", pix_eol, out_idx % XS == XS - 1);
        end
        if (eng_res_valid[1] && !eng_res_ready[1]) hold_cnt++;
        iss_hs = (exp_sv & eng_start_ready) != 0;
        res_hs = (exp_rr & eng_res_valid) != 0;
        pix_hs = out_full && pix_ready;
        if (pix_hs && cap_n < 8) begin
            cap[cap_n] = int'(pix_iter);
            cap_n++;
        end
        @(posedge aclk);
        #1;
        cyc++;
        for (int k = 0; k < NE; k++)
            if (has_job[k] && dly[k] > 0) dly[k]--;
        if (pix_hs) begin
            pix_cnt++;
            if (out_idx % FP == 0) sofs++;
            out_full = 0;
        end
        if (res_hs) begin
            has_job[rk] = 0;
            out_full = 1;
            out_idx = ret_n;
            ret_n++;
        end
        if (iss_hs) begin
            has_job[ik] = 1;
            job_iter[ik] = pix_val(iss_n);
            dly[ik] = rnd_dly ? int'($urandom_range(0, 6)) : fix_dly[ik];
            iss_n++;
            in_frame++;
        end
        if (fd) begin
            frames++;
            if (continuous) in_frame = 0;
            else busy_m = 0;
        end else if (!busy_m && frame_start) begin
            busy_m = 1;
            in_frame = 0;
        end
        drive();
    endtask

    task automatic run_frames(input int target, input int budget);
        int n = 0;
        while (frames < target && n < budget) begin
            step();
            n++;
        end
        check("frames_reached", frames, target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base_pix, base_sof, base_cyc, base_fr;
        areset = 1'b1; continuous = 1'b0; frame_start = 1'b0; pix_ready = 1'b0;
        eng_start_ready = '0; eng_res_valid = '0; eng_res_iter = '0;
        mult = 1; salt = 0; fix_dly[0] = 0; fix_dly[1] = 0;
        rnd_dly = 0; rnd_pix = 0; rnd_srdy = 0;
        hold_cnt = 0; cap_n = 0; pix_cnt = 0; frames = 0; sofs = 0; cyc = 0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check("reset_outputs", {busy, frame_done, eng_start_valid, eng_res_ready, pix_valid,
                                pix_sof, pix_eol, eng_x, eng_y, pix_iter}, 64'd0);
        areset = 1'b0;

        // 1: immediate engines, iter = x + 4y
        fs_req = 1; drive();
        run_frames(1, 100);
        repeat (4) step();
        check("t1_pixels", pix_cnt, 8);
        check("t1_sofs", sofs, 1);
        for (int k = 0; k < 8; k++) check("t1_iter_literal", cap[k], k);

        // 2: engine 0 slow, engine 1 fast
        mult = 29; salt = 3; fix_dly[0] = 9; fix_dly[1] = 2; hold_cnt = 0;
        fs_req = 1; drive();
        run_frames(2, 300);
        check("t2_pixels", pix_cnt, 16);
        check("t2_eng1_held", hold_cnt > 0, 1);

        // 3: random downstream stalls, engine latency and start-ready
        rnd_dly = 1; rnd_pix = 1; rnd_srdy = 1; salt = 77;
        for (int f = 0; f < 4; f++) begin
            fs_req = 1; drive();
            run_frames(3 + f, 600);
            repeat (3) step();
        end
        check("t3_pixels", pix_cnt, 48);
        rnd_dly = 0; rnd_pix = 0; rnd_srdy = 0; fix_dly[0] = 0; fix_dly[1] = 0;

        // 4: continuous, three frames back to back
        base_pix = pix_cnt; base_sof = sofs; base_cyc = cyc; base_fr = frames;
        continuous = 1'b1; fs_req = 1; drive();
        run_frames(base_fr + 2, 200);
        continuous = 1'b0;
        run_frames(base_fr + 3, 200);
        check("t4_pixels", pix_cnt - base_pix, 24);
        check("t4_sofs", sofs - base_sof, 3);
        check("t4_no_gap", (cyc - base_cyc) <= 40, 1);
        repeat (4) step();

        // 5: reset after three pixels
        base_pix = pix_cnt; base_fr = frames;
        rnd_pix = 1; salt = 5;
        fs_req = 1; drive();
        for (int n = 0; n < 200 && pix_cnt < base_pix + 3; n++) step();
        check("t5_three_out", pix_cnt - base_pix, 3);
        areset = 1'b1;
        #1;
        check("t5_reset_outputs", {busy, frame_done, eng_start_valid, eng_res_ready, pix_valid,
                                   pix_sof, pix_eol, eng_x, eng_y, pix_iter}, 64'd0);
        model_reset();
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check("t5_no_frame_done", frames, base_fr);
        base_pix = pix_cnt;
        fs_req = 1; drive();
        run_frames(base_fr + 1, 300);
        check("t5_restart_pixels", pix_cnt - base_pix, 8);
        rnd_pix = 0;

        // 6: frame_start hammered while busy
        base_pix = pix_cnt; base_fr = frames;
        rnd_fs = 1; fs_req = 1; drive();
        for (int n = 0; n < 200 && frames < base_fr + 1; n++) begin
            step();
            if (pix_cnt - base_pix >= 6) rnd_fs = 0;
        end
        rnd_fs = 0;
        repeat (10) step();
        check("t6_frames", frames - base_fr, 1);
        check("t6_pixels", pix_cnt - base_pix, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
